// File: rtl/i_decode_pkg.sv
// i_decode_pkg: LEGv8 decode constants (widths, XZR index, instruction field positions)
package i_decode_pkg;
  localparam int WORD = 64;
  localparam int INSTR_LEN = 32;
  localparam int CYCLE = 10;
  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] XZR = 5'd31;
  localparam int OPCODE_LSB = 21;
  localparam int OPCODE_W = 11;
  localparam int RM_LSB = 16;
  localparam int ADDR_LSB = 12;
  localparam int ADDR_W = 9;
  localparam int RN_LSB = 5;
  localparam int RD_LSB = 0;
endpackage

// File: rtl/i_decode_regfile.sv
// regfile: 32xWORD register file, two combinational reads, one write; XZR reads 0 and ignores writes (REGFILE_INIT_EN: preload X0-X30 from INIT parameter, reset only blocks writes)
module regfile
  import i_decode_pkg::*;
#(
  parameter logic [WORD-1:0] INIT [0:30] = '{default: '0}
)
(
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       raddr1,
  input  logic [4:0]       raddr2,
  input  logic             we,
  input  logic [4:0]       waddr,
  input  logic [WORD-1:0]  wdata,
  output logic [WORD-1:0]  rdata1,
  output logic [WORD-1:0]  rdata2
);
  logic [WORD-1:0] regs [0:31];
  // reads are unbuffered, so a same-cycle write shows only after the edge
  always_comb begin
    rdata1 = raddr1 == XZR ? '0 : regs[raddr1];
    rdata2 = raddr2 == XZR ? '0 : regs[raddr2];
  end
`ifdef REGFILE_INIT_EN
  initial for (int i = 0; i < 31; i++) regs[i] = INIT[i];
  // preloaded contents survive reset; a low reset at the edge just suppresses the write
  always_ff @(posedge clk)
    if (reset && we && waddr != XZR) regs[waddr] <= wdata;
`else
  // low reset clears the file at once; writes resume on the first edge after release
  always_ff @(posedge clk or negedge reset)
    if (!reset) for (int i = 0; i < 32; i++) regs[i] <= '0;
    else if (we && waddr != XZR) regs[waddr] <= wdata;
`endif
endmodule

// File: rtl/i_decode.sv
// i_decode: LEGv8 decode stage - field extraction, Reg2Loc read-port mux and register file (optional REGFILE_INIT_EN)
module i_decode
  import i_decode_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WORD-1:0]      nPC,
  input  logic [INSTR_LEN-1:0] Instruction,
  input  logic [WORD-1:0]      Write_data,
  input  logic                 Reg2Loc,
  input  logic                 RegWrite,
  output logic [4:0]           Rm_num,
  output logic [4:0]           Rn_num,
  output logic [4:0]           Rd_num,
  output logic [4:0]           Read_register1,
  output logic [4:0]           Read_register2,
  output logic [4:0]           Write_register,
  output logic [WORD-1:0]      Read_data1,
  output logic [WORD-1:0]      Read_data2,
  output logic [10:0]          Opcode,
  output logic [8:0]           Address
);
  logic unused_bits;
  assign unused_bits = ^{nPC, Instruction[11:10]};
  // fields follow the instruction directly; Reg2Loc picks Rt for stores/CBZ
  always_comb begin
    Opcode         = Instruction[OPCODE_LSB +: OPCODE_W];
    Rm_num         = Instruction[RM_LSB +: REG_W];
    Address        = Instruction[ADDR_LSB +: ADDR_W];
    Rn_num         = Instruction[RN_LSB +: REG_W];
    Rd_num         = Instruction[RD_LSB +: REG_W];
    Read_register1 = Rn_num;
    Read_register2 = Reg2Loc ? Rd_num : Rm_num;
    Write_register = Rd_num;
  end
  regfile u_regfile (
    .clk    (clk),
    .reset  (reset),
    .raddr1 (Read_register1),
    .raddr2 (Read_register2),
    .we     (RegWrite),
    .waddr  (Write_register),
    .wdata  (Write_data),
    .rdata1 (Read_data1),
    .rdata2 (Read_data2)
  );
endmodule

// File: tb/tb_i_decode.sv
// tb_i_decode: directed plan plus randomized traffic against an array model of the register file
module tb_i_decode;
  logic        clk = 0;
  logic        reset = 1;
  logic [63:0] nPC = 0;
  logic [31:0] Instruction = 0;
  logic [63:0] Write_data = 0;
  logic        Reg2Loc = 0;
  logic        RegWrite = 0;
  logic [4:0]  Rm_num, Rn_num, Rd_num, Read_register1, Read_register2, Write_register;
  logic [63:0] Read_data1, Read_data2;
  logic [10:0] Opcode;
  logic [8:0]  Address;

  logic [63:0] model [32];
  int total = 0;
  int passed = 0;

  i_decode dut (
    .clk(clk), .reset(reset), .nPC(nPC), .Instruction(Instruction),
    .Write_data(Write_data), .Reg2Loc(Reg2Loc), .RegWrite(RegWrite),
    .Rm_num(Rm_num), .Rn_num(Rn_num), .Rd_num(Rd_num),
    .Read_register1(Read_register1), .Read_register2(Read_register2),
    .Write_register(Write_register), .Read_data1(Read_data1),
    .Read_data2(Read_data2), .Opcode(Opcode), .Address(Address)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] xread(input int unsigned i);
    return (i == 31) ? 64'd0 : model[i];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_outputs(input string tag);
    int unsigned ins, rm, rn, rd, r2;
    ins = Instruction;
    rm = (ins / 65536) % 32;
    rn = (ins / 32) % 32;
    rd = ins % 32;
    r2 = Reg2Loc ? rd : rm;
    check({tag, "/opcode"}, 64'(Opcode), 64'(ins / 2097152));
    check({tag, "/rm"}, 64'(Rm_num), 64'(rm));
    check({tag, "/rn"}, 64'(Rn_num), 64'(rn));
    check({tag, "/rd"}, 64'(Rd_num), 64'(rd));
    check({tag, "/addr"}, 64'(Address), 64'((ins / 4096) % 512));
    check({tag, "/rr1"}, 64'(Read_register1), 64'(rn));
    check({tag, "/rr2"}, 64'(Read_register2), 64'(r2));
    check({tag, "/wr"}, 64'(Write_register), 64'(rd));
    check({tag, "/rd1"}, Read_data1, xread(rn));
    check({tag, "/rd2"}, Read_data2, xread(r2));
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 0;
  endtask

  task automatic cycle();
    @(posedge clk);
    if (reset && RegWrite && Instruction % 32 != 31) model[Instruction % 32] = Write_data;
    #1;
  endtask

  task automatic wr(input int unsigned idx, input logic [63:0] data);
    Instruction = ($urandom & ~32'h1f) | idx;
    Write_data = data;
    RegWrite = 1;
    cycle();
    RegWrite = 0;
    Write_data = 'x;
  endtask

  initial begin
    #2000000;
    $error("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_model();
    #2 reset = 0;
    #1 check_outputs("reset");
    @(posedge clk);
    #3 reset = 1;
    cycle();
    wr(21, 16);
    wr(9, 33);
    wr(10, 12);
    Instruction = 32'h8B150129;
    Reg2Loc = 0;
    #1;
    check("add/opcode", 64'(Opcode), 64'h458);
    check("add/rm", 64'(Rm_num), 21);
    check("add/rn", 64'(Rn_num), 9);
    check("add/rd", 64'(Rd_num), 9);
    check("add/addr", 64'(Address), 64'h150);
    check("add/rd1", Read_data1, 33);
    check("add/rd2", Read_data2, 16);
    check("add/wr", 64'(Write_register), 9);
    Write_data = 49;
    RegWrite = 1;
    #1 check("nobypass/rd1", Read_data1, 33);
    cycle();
    RegWrite = 0;
    check("wb/rd1", Read_data1, 49);
    Instruction = 32'hCB090149;
    #1;
    check("sub/opcode", 64'(Opcode), 64'h658);
    check("sub/rm", 64'(Rm_num), 9);
    check("sub/rn", 64'(Rn_num), 10);
    check("sub/rd", 64'(Rd_num), 9);
    check("sub/rd1", Read_data1, 12);
    check("sub/rd2", Read_data2, 49);
    Instruction = 32'hF8008149;
    Reg2Loc = 1;
    #1;
    check("stur/rr2", 64'(Read_register2), 9);
    check("stur/rd2", Read_data2, 49);
    check("stur/addr", 64'(Address), 64'h008);
    Reg2Loc = 0;
    Instruction = 32'h8B1F03FF;
    Write_data = 64'hDEAD;
    RegWrite = 1;
    cycle();
    RegWrite = 0;
    check("xzr/rd1", Read_data1, 0);
    check("xzr/rd2", Read_data2, 0);
    Instruction = 32'h8B090129;
    Write_data = 7;
    RegWrite = 0;
    cycle();
    check("weoff/rd1", Read_data1, 49);
    for (int n = 0; n < 300; n++) begin
      Instruction = $urandom;
      Reg2Loc = 1'($urandom);
      RegWrite = ($urandom % 4) != 0;
      Write_data = {$urandom, $urandom};
      nPC = {$urandom, $urandom};
      #1 check_outputs("rand");
      cycle();
    end
    RegWrite = 0;
    wr(5, 99);
    Instruction = 32'h8B0500A5;
    Reg2Loc = 0;
    #1 check("rst/pre", Read_data1, 99);
    #2 reset = 0;
    clear_model();
    #1 check("rst/async", Read_data1, 0);
    check_outputs("rst/all");
    Write_data = 55;
    RegWrite = 1;
    cycle();
    check("rst/blocked", Read_data1, 0);
    #3 reset = 1;
    cycle();
    RegWrite = 0;
    check("rst/release", Read_data1, 55);
    check_outputs("final");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/i_decode.md
# i_decode

Instruction-decode stage of the single-cycle LEGv8 datapath. Splits the 32-bit instruction into its register, opcode and address fields and selects the register-file read ports. Holds the 32×64-bit register file, with combinational reads and one synchronous write port fed from write-back. Sits between instruction fetch (which supplies nPC and the instruction) and execute (which consumes the read data, opcode and address).

## Interface
Parameters (constants from `definitions.vh`):
- `WORD`, 64, datapath and register width.
- `INSTR_LEN`, 32, instruction width.

Ports:
- `clk`  in  1  single clock; all writes occur on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `nPC`  in  WORD  next PC from fetch; reserved for branch-target logic and has no effect on any output.
- `Instruction`  in  INSTR_LEN  current instruction.
- `Write_data`  in  WORD  write-back value.
- `Reg2Loc`  in  1  selects the source of read port 2: 0 = Rm, 1 = Rd/Rt.
- `RegWrite`  in  1  write enable.
- `Rm_num`  out  5  Instruction[20:16].
- `Rn_num`  out  5  Instruction[9:5].
- `Rd_num`  out  5  Instruction[4:0].
- `Read_register1`  out  5  always Rn.
- `Read_register2`  out  5  Reg2Loc ? Rd : Rm.
- `Write_register`  out  5  always Rd.
- `Read_data1`  out  WORD  X[Read_register1].
- `Read_data2`  out  WORD  X[Read_register2].
- `Opcode`  out  11  Instruction[31:21].
- `Address`  out  9  Instruction[20:12], the D-type offset.

## Operation
- All field, mux and read outputs are purely combinational from `Instruction`, `Reg2Loc` and the register contents.
- Register 31 is XZR:
  - it always reads 0;
  - writes to it are discarded.
- Write condition: on a rising `clk` edge, if `reset` is high, `RegWrite` is 1 and `Write_register` != 31, then X[Write_register] <= `Write_data`.
- `RegWrite` = 0 leaves the file unchanged regardless of `Write_data`.
- `Write_data` is sampled only at the edge; it may be X at other times.
- While `reset` is low, all writes are blocked.
- The field outputs have no reset value; they follow `Instruction` at all times.

## Timing
- Reads have zero-cycle latency.
- A write becomes visible on `Read_data1`/`Read_data2` immediately after the writing edge.
- A read of the register being written in the same cycle returns the old value (no write-through bypass).
- Reset asserts asynchronously, with no clock needed. Deasserting reset makes the file writable from the next rising edge.
- If `reset` falls mid-cycle, no write occurs at the following edge.

## Configuration
- `REGFILE_INIT_EN` defined:
  - registers X0–X30 are initialised at time zero from the image file `fibR.data`;
  - `reset` only blocks writes and does not alter contents.
- `REGFILE_INIT_EN` undefined:
  - asserting `reset` asynchronously clears X0–X30 to 0;
  - no image file is read.

## Structure
- `definitions.vh` holds `WORD`, `INSTR_LEN`, `CYCLE`, the XZR index (31) and the field bit positions.
- One sub-module, `regfile`, holds the 32×WORD array. It has two combinational read ports and one write port, and owns the XZR and reset/init behaviour.
- `i_decode` contains only field extraction, the Reg2Loc mux and wiring.
- `oscillator` is a bench-only clock source with period `CYCLE`. It is not part of the RTL.

## Test plan
- **ADD decode and read.** `REGFILE_INIT_EN` set; image has X21=16, X9=33, X10=12. Inputs: `Instruction` 0x8B150129, `Reg2Loc`=0. Required:
  - `Opcode`=0x458, `Rm_num`=21, `Rn_num`=9, `Rd_num`=9, `Address`=0x150;
  - `Read_data1`=33, `Read_data2`=16, `Write_register`=9.
- **Write-back then SUB.** From the ADD state, apply `Write_data`=49 with `RegWrite`=1 across one edge, then `Instruction` 0xCB090149. Required:
  - `Opcode`=0x658, `Rm_num`=9, `Rn_num`=10, `Rd_num`=9;
  - `Read_data1`=12, `Read_data2`=49.
- **Reg2Loc = 1.** Inputs: `Instruction` 0xF8008149 (STUR X9,[X10,#8]), `Reg2Loc`=1. Required:
  - `Read_register2`=9, `Read_data2`=X9, `Address`=0x008.
- **XZR.** Write 0xDEAD to Rd=31 with `RegWrite`=1. Required: `Read_data1`=0 when Rn=31.
- **Write enable off.** `RegWrite`=0 with `Write_data`=7 across an edge. Required: the target register is unchanged.
- **Reset.** `REGFILE_INIT_EN` undefined. Write X5=99, then pulse `reset` low between clock edges. Required:
  - X5 reads 0 immediately, without waiting for an edge;
  - a write attempted while `reset` is low is ignored.
